// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 register indices, exception codes and field positions
package cp0_pkg;

    localparam logic [4:0] RDC_BADVADDR = 5'd8;
    localparam logic [4:0] RDC_COUNT    = 5'd9;
    localparam logic [4:0] RDC_COMPARE  = 5'd11;
    localparam logic [4:0] RDC_STATUS   = 5'd12;
    localparam logic [4:0] RDC_CAUSE    = 5'd13;
    localparam logic [4:0] RDC_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT    = 5'h00,
        EXC_HLT    = 5'h01,
        EXC_RESUME = 5'h02,
        EXC_ADEL   = 5'h04,
        EXC_ADES   = 5'h05,
        EXC_SYS    = 5'h08,
        EXC_BP     = 5'h09,
        EXC_RI     = 5'h0a,
        EXC_OF     = 5'h0c
    } exc_code_e;

    // Status field positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam logic [15:0] ST_FIXED_HI = 16'h0040;

    // Cause field positions
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    function automatic logic is_addr_err(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// rtl/cp0_count_timer.sv - prescaled Count, Compare and timer interrupt flag
module cp0_count_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc;
    logic          inc_d;
    logic          wrap;

    assign wrap = (presc == PRESC_MAX);

    // inc_d marks that Count moved last cycle, so the match is judged on the new value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
            inc_d   <= 1'b0;
        end else begin
            inc_d <= 1'b0;
            if (count_we) begin
                count <= wdata;
                presc <= '0;
            end else begin
                presc <= wrap ? '0 : presc + PW'(1);
                if (wrap) begin
                    count <= count + 32'd1;
                    inc_d <= 1'b1;
                end
            end
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (inc_d && (count == compare)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_timer_ctrl.sv
// rtl/cp0_timer_ctrl.sv - coprocessor-0 with Status/Cause/EPC, halt, BadVAddr and Count/Compare timer
module cp0_timer_ctrl
    import cp0_pkg::*;
#(
    parameter int          HW_INT_NUM  = 5,
    parameter int          TIMER_EN    = 1,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] EX_ENTRY_PC = 32'h0040_0008,
    parameter logic [31:0] EX_HLT_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cp0_we,
    input  logic [4:0]            cp0_rdc,
    input  logic [31:0]           cp0_data_in,
    output logic [31:0]           cp0_data_out,
    input  logic                  ex_wb,
    input  logic [4:0]            ex_code,
    input  logic                  eret_flush,
    input  logic                  branch_delay_wb,
    input  logic [31:0]           epc_in,
    input  logic [31:0]           badvaddr_in,
    input  logic [HW_INT_NUM-1:0] int_sig_in,
    output logic                  ex,
    output logic                  flush,
    output logic [31:0]           epc_out,
    output logic                  int_req,
    output logic                  timer_int,
    output logic                  hlt,
    output logic                  ie,
    output logic                  exl
);

    logic [7:0]            im;
    logic [1:0]            ip_sw;
    logic [HW_INT_NUM-1:0] ip_hw;
    logic [7:0]            ip;
    logic                  bd;
    logic [4:0]            exc_code;
    logic [31:0]           epc;
    logic [31:0]           badvaddr;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  ti;

    logic status_we, cause_we, epc_we, count_we, compare_we;
    logic epc_capture;
    logic [31:0] epc_fault;

    assign status_we  = cp0_we && (cp0_rdc == RDC_STATUS);
    assign cause_we   = cp0_we && (cp0_rdc == RDC_CAUSE);
    assign epc_we     = cp0_we && (cp0_rdc == RDC_EPC);
    assign count_we   = cp0_we && (cp0_rdc == RDC_COUNT);
    assign compare_we = cp0_we && (cp0_rdc == RDC_COMPARE);

    // Nested exceptions and halted state keep the original return address
    assign epc_capture = ex_wb && !exl && !hlt;
    assign epc_fault   = branch_delay_wb ? (epc_in - 32'd4) : epc_in;

    generate
        if (TIMER_EN != 0) begin : g_timer
            cp0_count_timer #(
                .COUNT_DIV (COUNT_DIV)
            ) u_count_timer (
                .clk        (clk),
                .rst        (rst),
                .count_we   (count_we),
                .compare_we (compare_we),
                .wdata      (cp0_data_in),
                .count      (count),
                .compare    (compare),
                .ti         (ti)
            );
        end else begin : g_no_timer
            assign count   = '0;
            assign compare = '0;
            assign ti      = 1'b0;
        end
    endgenerate

    always_comb begin
        ip       = '0;
        ip[1:0]  = ip_sw;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            ip[2+i] = ip_hw[i];
        end
        if (TIMER_EN != 0) begin
            ip[7] = ti;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hlt      <= 1'b0;
            ie       <= 1'b0;
            exl      <= 1'b0;
            im       <= 8'hFF;
            ip_sw    <= 2'b00;
            ip_hw    <= '0;
            bd       <= 1'b0;
            exc_code <= 5'h00;
            epc      <= '0;
            badvaddr <= '0;
            int_req  <= 1'b0;
        end else begin
            ip_hw <= int_sig_in;

            if (ex_wb) begin
                exl <= 1'b1;
            end else if (eret_flush) begin
                exl <= 1'b0;
            end else if (status_we) begin
                exl <= cp0_data_in[ST_EXL];
            end

            if (status_we) begin
                ie <= cp0_data_in[ST_IE];
                im <= cp0_data_in[ST_IM_LO +: 8];
            end

            if (cause_we) begin
                ip_sw <= cp0_data_in[CA_IP_LO +: 2];
            end

            if (ex_wb && !exl) begin
                bd <= branch_delay_wb;
            end

            if (epc_capture) begin
                epc <= epc_fault;
            end else if (epc_we) begin
                epc <= cp0_data_in;
            end

            if (ex_wb) begin
                exc_code <= ex_code;
                if (is_addr_err(ex_code)) begin
                    badvaddr <= badvaddr_in;
                end
                if (ex_code == EXC_HLT) begin
                    hlt <= 1'b1;
                end else if (ex_code == EXC_RESUME) begin
                    hlt <= 1'b0;
                end
            end

            int_req <= ie && !exl && !hlt && |(ip & im);
        end
    end

    always_comb begin
        cp0_data_out = '0;
        case (cp0_rdc)
            RDC_BADVADDR: cp0_data_out = badvaddr;
            RDC_COUNT:    cp0_data_out = count;
            RDC_COMPARE:  cp0_data_out = compare;
            RDC_STATUS:   cp0_data_out = {ST_FIXED_HI, im, 6'b0, exl, ie};
            RDC_CAUSE:    cp0_data_out = {bd, ti, 14'b0, ip, 1'b0, exc_code, 2'b0};
            RDC_EPC:      cp0_data_out = epc;
            default:      cp0_data_out = '0;
        endcase
    end

    assign ex        = ex_wb;
    assign flush     = ex_wb | eret_flush;
    assign epc_out   = ex_wb ? EX_ENTRY_PC : (hlt ? EX_HLT_PC : epc);
    assign timer_int = ti;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// tb/tb_cp0_timer_ctrl.sv - self-checking bench for cp0_timer_ctrl
module tb_cp0_timer_ctrl;

    localparam int HW  = 5;
    localparam int DIV = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cp0_we;
    logic [4:0]    cp0_rdc;
    logic [31:0]   cp0_data_in;
    logic [31:0]   cp0_data_out;
    logic          ex_wb;
    logic [4:0]    ex_code;
    logic          eret_flush;
    logic          branch_delay_wb;
    logic [31:0]   epc_in;
    logic [31:0]   badvaddr_in;
    logic [HW-1:0] int_sig_in;
    logic          ex, flush, int_req, timer_int, hlt, ie, exl;
    logic [31:0]   epc_out;

    always #5 clk = ~clk;

    cp0_timer_ctrl #(
        .HW_INT_NUM  (HW),
        .TIMER_EN    (1),
        .COUNT_DIV   (DIV),
        .EX_ENTRY_PC (32'h0040_0008),
        .EX_HLT_PC   (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cp0_we          (cp0_we),
        .cp0_rdc         (cp0_rdc),
        .cp0_data_in     (cp0_data_in),
        .cp0_data_out    (cp0_data_out),
        .ex_wb           (ex_wb),
        .ex_code         (ex_code),
        .eret_flush      (eret_flush),
        .branch_delay_wb (branch_delay_wb),
        .epc_in          (epc_in),
        .badvaddr_in     (badvaddr_in),
        .int_sig_in      (int_sig_in),
        .ex              (ex),
        .flush           (flush),
        .epc_out         (epc_out),
        .int_req         (int_req),
        .timer_int       (timer_int),
        .hlt             (hlt),
        .ie              (ie),
        .exl             (exl)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rdc, input logic [31:0] d,
                         input logic exw, input logic [4:0] code, input logic er,
                         input logic bd, input logic [31:0] pc, input logic [31:0] bva,
                         input logic [HW-1:0] irq);
        cp0_we = we; cp0_rdc = rdc; cp0_data_in = d;
        ex_wb = exw; ex_code = code; eret_flush = er;
        branch_delay_wb = bd; epc_in = pc; badvaddr_in = bva; int_sig_in = irq;
    endtask

    task automatic idle(input logic [4:0] rdc);
        drive(1'b0, rdc, 32'h0, 1'b0, 5'h0, 1'b0, 1'b0, 32'h0, 32'h0, '0);
    endtask

    task automatic wr(input logic [4:0] rdc, input logic [31:0] d);
        drive(1'b1, rdc, d, 1'b0, 5'h0, 1'b0, 1'b0, 32'h0, 32'h0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: Count is derived arithmetically from the last load point
    logic [31:0]   m_lv, m_cmp, m_epc, m_bva;
    int            m_n, m_lc;
    logic          m_ti, m_hlt, m_ie, m_exl, m_bd, m_ir;
    logic [7:0]    m_im;
    logic [1:0]    m_ipsw;
    logic [HW-1:0] m_iphw;
    logic [4:0]    m_code;

    function automatic logic [31:0] m_count();
        return m_lv + 32'((m_n - m_lc) / DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_ti, m_iphw, m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rdc);
        case (rdc)
            5'd8:    return m_bva;
            5'd9:    return m_count();
            5'd11:   return m_cmp;
            5'd12:   return {16'h0040, m_im, 6'b0, m_exl, m_ie};
            5'd13:   return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic inc_now, ir_n, cw;
        logic [31:0] cnt;
        inc_now = (m_n > m_lc) && (((m_n - m_lc) % DIV) == 0);
        cnt     = m_count();
        ir_n    = m_ie && !m_exl && !m_hlt && (|(m_ip() & m_im));
        cw      = cp0_we && cp0_rdc == 5'd11;
        if (cw) m_ti = 1'b0;
        else if (inc_now && cnt == m_cmp) m_ti = 1'b1;
        if (cw) m_cmp = cp0_data_in;
        if (ex_wb && !m_exl && !m_hlt) m_epc = branch_delay_wb ? epc_in - 32'd4 : epc_in;
        else if (cp0_we && cp0_rdc == 5'd14) m_epc = cp0_data_in;
        if (ex_wb && !m_exl) m_bd = branch_delay_wb;
        if (ex_wb) m_code = ex_code;
        if (ex_wb && (ex_code == 5'h04 || ex_code == 5'h05)) m_bva = badvaddr_in;
        if (ex_wb && ex_code == 5'h01) m_hlt = 1'b1;
        else if (ex_wb && ex_code == 5'h02) m_hlt = 1'b0;
        if (ex_wb) m_exl = 1'b1;
        else if (eret_flush) m_exl = 1'b0;
        else if (cp0_we && cp0_rdc == 5'd12) m_exl = cp0_data_in[1];
        if (cp0_we && cp0_rdc == 5'd12) begin
            m_ie = cp0_data_in[0];
            m_im = cp0_data_in[15:8];
        end
        if (cp0_we && cp0_rdc == 5'd13) m_ipsw = cp0_data_in[9:8];
        m_iphw = int_sig_in;
        m_n++;
        if (cp0_we && cp0_rdc == 5'd9) begin
            m_lv = cp0_data_in;
            m_lc = m_n;
        end
        m_ir = ir_n;
    endtask

    typedef struct {
        logic we; logic [4:0] rdc; logic [31:0] d;
        logic exw; logic [4:0] code; logic er; logic bd;
        logic [31:0] pc; logic [31:0] bva; logic [HW-1:0] irq;
        logic [31:0] e_rd; logic [31:0] e_epc; logic e_exl; logic e_hlt; logic e_ir;
    } vec_t;

    vec_t tbl[19];
    int   exp_cnt[4];
    logic [4:0] rdc_pool[9];
    logic [4:0] code_pool[7];

    initial begin
        //         we    rdc    data          exw   code   er    bd    epc_in        badvaddr      irq     rd            epc_out       exl   hlt   ir
        tbl[0]  = '{1'b0, 5'd12, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h0040FF00, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd13, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd12, 32'h0000FF01, 1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h0040FF00, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 5'd14, 32'h0,        1'b1, 5'h4, 1'b0, 1'b1, 32'h00400100, 32'h12345679, 5'd0, 32'h0,        32'h00400008, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd14, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h004000FC, 32'h004000FC, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd8,  32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h12345679, 32'h004000FC, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd13, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h80000010, 32'h004000FC, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd12, 32'h0,        1'b0, 5'h0, 1'b1, 1'b0, 32'h0,        32'h0,        5'd0, 32'h0040FF03, 32'h004000FC, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd13, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd1, 32'h80000010, 32'h004000FC, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd13, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd1, 32'h80000410, 32'h004000FC, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 5'd12, 32'h0000FB01, 1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd1, 32'h0040FF01, 32'h004000FC, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 5'd12, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd1, 32'h0040FB01, 32'h004000FC, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 5'd14, 32'h0,        1'b1, 5'h1, 1'b0, 1'b0, 32'h00400200, 32'h0,        5'd0, 32'h004000FC, 32'h00400008, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 5'd14, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h00400200, 32'h0,        1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 5'd14, 32'h0,        1'b0, 5'h0, 1'b1, 1'b0, 32'h0,        32'h0,        5'd0, 32'h00400200, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 5'd14, 32'h0,        1'b1, 5'h8, 1'b0, 1'b0, 32'h00400300, 32'h0,        5'd0, 32'h00400200, 32'h00400008, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 5'd14, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h00400200, 32'h0,        1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 5'd13, 32'h0,        1'b1, 5'h2, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h00000020, 32'h00400008, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 5'd14, 32'h0,        1'b0, 5'h0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 32'h00400200, 32'h00400200, 1'b1, 1'b0, 1'b0};
        exp_cnt   = '{5, 6, 6, 7};
        rdc_pool  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd20, 5'd15};
        code_pool = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h05, 5'h08, 5'h0c};

        // reset state
        idle(5'd12);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_status", cp0_data_out, 32'h0040FF00);
        idle(5'd13);
        #1;
        chk("rst_cause", cp0_data_out, 32'h0);
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        rst = 1'b1;

        // directed exception / interrupt / halt table
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].we, tbl[i].rdc, tbl[i].d, tbl[i].exw, tbl[i].code, tbl[i].er,
                  tbl[i].bd, tbl[i].pc, tbl[i].bva, tbl[i].irq);
            #1;
            chk($sformatf("tbl%0d_rd", i), cp0_data_out, tbl[i].e_rd);
            chk($sformatf("tbl%0d_epc_out", i), epc_out, tbl[i].e_epc);
            tick();
            chk($sformatf("tbl%0d_exl", i), {31'b0, exl}, {31'b0, tbl[i].e_exl});
            chk($sformatf("tbl%0d_hlt", i), {31'b0, hlt}, {31'b0, tbl[i].e_hlt});
            chk($sformatf("tbl%0d_int_req", i), {31'b0, int_req}, {31'b0, tbl[i].e_ir});
        end

        // Count/Compare timer interrupt
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'h0, 1'b1, 1'b0, 32'h0, 32'h0, '0);
        tick();
        wr(5'd11, 32'd7);
        tick();
        wr(5'd9, 32'd5);
        tick();
        for (int k = 0; k < 4; k++) begin
            idle(5'd9);
            tick();
            chk($sformatf("cnt_step%0d", k + 1), cp0_data_out, 32'(exp_cnt[k]));
        end
        chk("ti_before_match", {31'b0, timer_int}, 32'h0);
        tick();
        chk("ti_set", {31'b0, timer_int}, 32'h1);
        tick();
        chk("ti_int_req", {31'b0, int_req}, 32'h1);
        wr(5'd11, 32'h100);
        tick();
        chk("ti_clear", {31'b0, timer_int}, 32'h0);
        idle(5'd9);
        tick();
        chk("ti_int_req_drop", {31'b0, int_req}, 32'h0);

        // Count wrap without and with Compare=0
        wr(5'd9, 32'hFFFF_FFFF);
        tick();
        idle(5'd9);
        repeat (2) tick();
        chk("wrap_count", cp0_data_out, 32'h0);
        tick();
        chk("wrap_no_ti", {31'b0, timer_int}, 32'h0);
        wr(5'd11, 32'h0);
        tick();
        wr(5'd9, 32'hFFFF_FFFF);
        tick();
        idle(5'd9);
        repeat (2) tick();
        chk("wrap0_count", cp0_data_out, 32'h0);
        tick();
        chk("wrap0_ti", {31'b0, timer_int}, 32'h1);

        // reset mid-operation
        idle(5'd12);
        rst = 1'b0;
        #1;
        chk("mid_rst_status", cp0_data_out, 32'h0040FF00);
        chk("mid_rst_ti", {31'b0, timer_int}, 32'h0);
        chk("mid_rst_int_req", {31'b0, int_req}, 32'h0);
        idle(5'd9);
        #1;
        chk("mid_rst_count", cp0_data_out, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("rel_count_e1", cp0_data_out, 32'h0);
        tick();
        chk("rel_count_e2", cp0_data_out, 32'h1);

        // randomized run against the model, starting from the post-reset state
        m_lv = '0; m_lc = 0; m_n = 2; m_cmp = '0; m_epc = '0; m_bva = '0;
        m_ti = 0; m_hlt = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ir = 0;
        m_im = 8'hFF; m_ipsw = '0; m_iphw = '0; m_code = '0;
        for (int i = 0; i < 400; i++) begin
            logic        we, exw, er;
            logic [4:0]  rdc;
            logic [31:0] d;
            we  = ($urandom % 4) == 0;
            rdc = rdc_pool[$urandom % 9];
            d   = $urandom;
            if (rdc == 5'd9)  d = m_cmp - 32'($urandom_range(0, 3));
            if (rdc == 5'd11) d = m_count() + 32'($urandom_range(1, 6));
            if (rdc == 5'd12 && ($urandom % 4) != 0) d[1:0] = 2'b01;
            exw = ($urandom % 8) == 0;
            er  = ($urandom % 8) == 0;
            drive(we, rdc, d, exw, code_pool[$urandom % 7], er, 1'($urandom),
                  $urandom, $urandom, HW'($urandom));
            #1;
            chk($sformatf("rnd%0d_rd", i), cp0_data_out, m_read(rdc));
            chk($sformatf("rnd%0d_epc_out", i), epc_out,
                exw ? 32'h00400008 : (m_hlt ? 32'h0 : m_epc));
            chk($sformatf("rnd%0d_flush", i), {30'b0, ex, flush}, {30'b0, exw, exw | er});
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rnd%0d_state", i), {27'b0, hlt, ie, exl, int_req, timer_int},
                {27'b0, m_hlt, m_ie, m_exl, m_ir, m_ti});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
